// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package serial_adder_pkg;

    // Operand/result width used when the instantiating design does not override it.
    localparam int SA_DEFAULT_WIDTH = 8;

    // Controller states for serial_adder.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } sa_state_e;

endpackage

// File: rtl/full_adder_cell.sv
// One-bit full adder built from two half adders; the two partial carries are ORed.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: a, b, cin (addend bits and carry in); sum, cout (sum bit and carry out).
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic ab_sum;
    logic ab_carry;
    logic c_carry;

    half_adder u_ha_ab (
        .a     (a),
        .b     (b),
        .sum   (ab_sum),
        .carry (ab_carry)
    );

    half_adder u_ha_c (
        .a     (ab_sum),
        .b     (cin),
        .sum   (sum),
        .carry (c_carry)
    );

    // At most one of the two half adders can produce a carry, so OR is exact.
    assign cout = ab_carry | c_carry;

endmodule

// File: rtl/half_adder.sv
// Combinational half adder: sum = a ^ b, carry = a & b.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: a, b (addend bits); sum, carry (results).
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one full-adder cell plus registered carry.
// Latency: start accepted at edge k -> busy for WIDTH cycles -> done pulse one cycle later.
// Backpressure: start is only honoured in IDLE or DONE; it is ignored while busy.
//
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   start                 begin an addition (sampled in IDLE/DONE only)
//   operand_A, operand_B  addends, captured on an accepted start
//   carry_in              initial carry, captured on an accepted start
//   busy                  high while bits are being processed
//   done                  one-cycle completion pulse
//   result, carry_out     sum and final carry, held until the next accepted start
//   overflow              signed overflow flag
//
// Build option: define SERIAL_ADDER_OVF_EN to compute overflow; otherwise it is tied to 0.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = SA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] operand_A,
    input  logic [WIDTH-1:0] operand_B,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    sa_state_e        state;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] result_reg;
    logic             carry_reg;
    logic [CNT_W-1:0] bit_cnt;

    logic fa_sum;
    logic fa_carry;
    logic load;
    logic last_bit;

    // The single shared full adder always looks at the current LSBs and carry.
    full_adder_cell u_fa (
        .a    (a_reg[0]),
        .b    (b_reg[0]),
        .cin  (carry_reg),
        .sum  (fa_sum),
        .cout (fa_carry)
    );

    assign load     = start && ((state == IDLE) || (state == DONE));
    assign last_bit = (state == SHIFT) && (bit_cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            carry_reg  <= 1'b0;
            bit_cnt    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_reg      <= operand_A;
                        b_reg      <= operand_B;
                        carry_reg  <= carry_in;
                        bit_cnt    <= '0;
                        result_reg <= '0;
                        state      <= SHIFT;
                    end else begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    // Sum bits enter at the MSB so that after WIDTH shifts
                    // bit 0 of the sum has reached bit 0 of result_reg.
                    result_reg <= {fa_sum, result_reg[WIDTH-1:1]};
                    a_reg      <= {1'b0, a_reg[WIDTH-1:1]};
                    b_reg      <= {1'b0, b_reg[WIDTH-1:1]};
                    carry_reg  <= fa_carry;
                    bit_cnt    <= bit_cnt + CNT_W'(1);
                    if (last_bit) begin
                        state <= DONE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef SERIAL_ADDER_OVF_EN
    // During the final SHIFT cycle carry_reg is the carry into the MSB and
    // fa_carry is the carry out of it; their XOR is the signed overflow.
    // Capturing the XOR directly is equivalent to keeping the carry-in flop
    // and XORing it with carry_reg afterwards, and it stays stable through
    // IDLE because carry_reg does not change there.
    logic ovf_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_reg <= 1'b0;
        end else if (load) begin
            ovf_reg <= 1'b0;
        end else if (last_bit) begin
            ovf_reg <= carry_reg ^ fa_carry;
        end
    end

    assign overflow = ovf_reg;
`else
    assign overflow = 1'b0;
`endif

    assign busy      = (state == SHIFT);
    assign done      = (state == DONE);
    assign result    = result_reg;
    assign carry_out = carry_reg;

endmodule
